// File: rtl/fll_reg_responder.sv
// ----------------------------------------------------------------------------
// fll_reg_responder
//
// Responder end of the FLL register bus. Terminates the four-phase req/ack
// handshake from the APB-side initiator, brings the asynchronous request into
// the FLL clock domain, and serves reads/writes on a small register file:
//   address 0               : STATUS  {meas_cnt, 14'b0, sticky_loss, lock}
//   address 1..NUM_REGS-1   : CONFIG  (read/write, reset to RST_VAL)
//   address >= NUM_REGS     : reads 0, writes ignored, still acknowledged
//
// Ports
//   clk_i        in   responder clock (only clock)
//   rst_i        in   synchronous active-high reset
//   fll_req_i    in   handshake request, asynchronous to clk_i
//   fll_web_i    in   0 = write, 1 = read (stable while req is high)
//   fll_addr_i   in   register address (stable while req is high)
//   fll_wdata_i  in   write data (stable while req is high)
//   fll_rdata_o  out  read data, valid while ack is high, held afterwards
//   fll_ack_o    out  handshake acknowledge
//   lock_i       in   FLL lock indication, synchronous to clk_i
//   meas_cnt_i   in   FLL measured cycle count, synchronous to clk_i
//   cfg_o        out  CONFIG n at bits [(n-1)*32 +: 32]
//   cfg_we_o     out  one-cycle write strobe, bit n-1 for CONFIG n
//
// Every output comes straight from a flop; the bus inputs only reach the
// outputs through the registered access edge.
// ----------------------------------------------------------------------------
module fll_reg_responder #(
    parameter int unsigned NUM_REGS = 4,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         fll_req_i,
    input  logic                         fll_web_i,
    input  logic [3:0]                   fll_addr_i,
    input  logic [31:0]                  fll_wdata_i,
    output logic [31:0]                  fll_rdata_o,
    output logic                         fll_ack_o,

    input  logic                         lock_i,
    input  logic [15:0]                  meas_cnt_i,

    output logic [(NUM_REGS-1)*32-1:0]   cfg_o,
    output logic [NUM_REGS-2:0]          cfg_we_o
);

    localparam int unsigned NUM_CFG = NUM_REGS - 1;
    localparam int unsigned CFG_W   = NUM_CFG * 32;

    // Handshake state: IDLE waits for a synchronized request, ACK holds the
    // acknowledge until the synchronized request has returned low.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e                 state_q,       state_d;
    logic                   req_s0_q,      req_s0_d;
    logic                   req_s_q,       req_s_d;
    logic                   ack_q,         ack_d;
    logic [31:0]            rdata_q,       rdata_d;
    logic                   lock_q,        lock_d;
    logic                   sticky_loss_q, sticky_loss_d;
    logic [CFG_W-1:0]       cfg_q,         cfg_d;
    logic [NUM_CFG-1:0]     cfg_we_q,      cfg_we_d;

    logic                   sticky_clr;
    logic                   lock_fall;
    logic [31:0]            status_word;

    // STATUS reports the sticky bit as it stood before this edge, so a read
    // racing a lock loss still shows the older state and the next read the
    // new one.
    assign status_word = {meas_cnt_i, 14'd0, sticky_loss_q, lock_i};
    assign lock_fall   = lock_q & ~lock_i;

    // Next-state logic. The access happens only on the IDLE -> ACK transition,
    // which gives exactly one register operation per request pulse no matter
    // how long the initiator keeps req high.
    always_comb begin
        state_d    = state_q;
        req_s0_d   = fll_req_i;
        req_s_d    = req_s0_q;
        ack_d      = ack_q;
        rdata_d    = rdata_q;
        lock_d     = lock_i;
        cfg_d      = cfg_q;
        cfg_we_d   = '0;
        sticky_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s_q) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                    if (!fll_web_i) begin
                        // Writing STATUS only ever clears the sticky flag,
                        // and only when bit 1 is set; other bits are ignored.
                        if (fll_addr_i == 4'd0) begin
                            sticky_clr = fll_wdata_i[1];
                        end
                        for (int n = 1; n < int'(NUM_REGS); n++) begin
                            if (fll_addr_i == 4'(n)) begin
                                cfg_d[(n-1)*32 +: 32] = fll_wdata_i;
                                cfg_we_d[n-1]         = 1'b1;
                            end
                        end
                    end else begin
                        // Unmapped addresses fall through to zero.
                        rdata_d = 32'h0000_0000;
                        if (fll_addr_i == 4'd0) begin
                            rdata_d = status_word;
                        end
                        for (int n = 1; n < int'(NUM_REGS); n++) begin
                            if (fll_addr_i == 4'(n)) begin
                                rdata_d = cfg_q[(n-1)*32 +: 32];
                            end
                        end
                    end
                end
            end
            ACK: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A lock loss on the same edge as a clear must not be lost.
        if (lock_fall) begin
            sticky_loss_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_loss_d = 1'b0;
        end else begin
            sticky_loss_d = sticky_loss_q;
        end
    end

    // State registers. Reset also clears the synchronizer so a request that
    // is still high when reset releases is treated as a fresh access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_s0_q      <= 1'b0;
            req_s_q       <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= 32'h0000_0000;
            lock_q        <= 1'b0;
            sticky_loss_q <= 1'b0;
            cfg_q         <= {NUM_CFG{RST_VAL}};
            cfg_we_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_s0_q      <= req_s0_d;
            req_s_q       <= req_s_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            lock_q        <= lock_d;
            sticky_loss_q <= sticky_loss_d;
            cfg_q         <= cfg_d;
            cfg_we_q      <= cfg_we_d;
        end
    end

    assign fll_ack_o   = ack_q;
    assign fll_rdata_o = rdata_q;
    assign cfg_o       = cfg_q;
    assign cfg_we_o    = cfg_we_q;

endmodule

// File: tb/tb_fll_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_fll_reg_responder
//
// Directed bench for fll_reg_responder with NUM_REGS=4, RST_VAL=32'hA5.
// Expected transaction results are queued when a request is driven and
// popped when the responder raises ack.
// ----------------------------------------------------------------------------
module tb_fll_reg_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fll_req_i;
    logic        fll_web_i;
    logic [3:0]  fll_addr_i;
    logic [31:0] fll_wdata_i;
    logic [31:0] fll_rdata_o;
    logic        fll_ack_o;
    logic        lock_i;
    logic [15:0] meas_cnt_i;
    logic [95:0] cfg_o;
    logic [2:0]  cfg_we_o;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string       tag;
        logic        is_read;
        logic [31:0] rdata;
        logic [2:0]  we;
    } exp_t;

    exp_t sb_q[$];

    fll_reg_responder #(
        .NUM_REGS (4),
        .RST_VAL  (32'h0000_00A5)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fll_req_i   (fll_req_i),
        .fll_web_i   (fll_web_i),
        .fll_addr_i  (fll_addr_i),
        .fll_wdata_i (fll_wdata_i),
        .fll_rdata_o (fll_rdata_o),
        .fll_ack_o   (fll_ack_o),
        .lock_i      (lock_i),
        .meas_cnt_i  (meas_cnt_i),
        .cfg_o       (cfg_o),
        .cfg_we_o    (cfg_we_o)
    );

    always #5 clk_i = ~clk_i;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full four-phase transaction with cycle-exact ack checks. When
    // lock_fall is set, lock_i drops so that its falling edge lands on the
    // access edge itself.
    task automatic applyStimulus(input string tag, input logic web,
                                 input logic [3:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic [2:0] exp_we,
                                 input logic lock_fall);
        exp_t e;
        exp_t got;
        e.tag     = tag;
        e.is_read = web;
        e.rdata   = exp_rdata;
        e.we      = exp_we;
        sb_q.push_back(e);

        fll_web_i   = web;
        fll_addr_i  = addr;
        fll_wdata_i = wdata;
        fll_req_i   = 1'b1;

        tick();
        checkOutput({tag, "_ack_k"}, 96'(fll_ack_o), 96'd0);
        tick();
        checkOutput({tag, "_ack_k1"}, 96'(fll_ack_o), 96'd0);
        if (lock_fall) lock_i = 1'b0;
        tick();
        checkOutput({tag, "_ack_k2"}, 96'(fll_ack_o), 96'd1);
        if (sb_q.size() == 0) begin
            assert_count++;
            fail_count++;
            $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            got = sb_q.pop_front();
            if (got.is_read)
                checkOutput({got.tag, "_rdata"}, 96'(fll_rdata_o), 96'(got.rdata));
            checkOutput({got.tag, "_we"}, 96'(cfg_we_o), 96'(got.we));
        end
        tick();
        checkOutput({tag, "_we_off"}, 96'(cfg_we_o), 96'd0);
        checkOutput({tag, "_ack_hold"}, 96'(fll_ack_o), 96'd1);

        fll_req_i = 1'b0;
        tick();
        tick();
        checkOutput({tag, "_ack_m1"}, 96'(fll_ack_o), 96'd1);
        tick();
        checkOutput({tag, "_ack_m2"}, 96'(fll_ack_o), 96'd0);
    endtask

    initial begin
        int   pulses;
        exp_t e;
        exp_t got;

        rst_i       = 1'b1;
        fll_req_i   = 1'b0;
        fll_web_i   = 1'b1;
        fll_addr_i  = 4'd0;
        fll_wdata_i = 32'd0;
        lock_i      = 1'b1;
        meas_cnt_i  = 16'h1234;

        // Reset
        tick();
        tick();
        checkOutput("rst_ack",   96'(fll_ack_o),   96'd0);
        checkOutput("rst_rdata", 96'(fll_rdata_o), 96'd0);
        checkOutput("rst_cfg",   cfg_o, {32'hA5, 32'hA5, 32'hA5});
        checkOutput("rst_we",    96'(cfg_we_o),    96'd0);
        rst_i = 1'b0;
        tick();

        // CONFIG writes and reads
        applyStimulus("wr2", 1'b0, 4'd2, 32'hDEAD_BEEF, 32'd0, 3'b010, 1'b0);
        checkOutput("wr2_cfg", cfg_o, {32'hA5, 32'hDEAD_BEEF, 32'hA5});
        applyStimulus("rd2", 1'b1, 4'd2, 32'd0, 32'hDEAD_BEEF, 3'b000, 1'b0);
        applyStimulus("wr1", 1'b0, 4'd1, 32'h1111_1111, 32'd0, 3'b001, 1'b0);
        applyStimulus("wr3", 1'b0, 4'd3, 32'h3333_3333, 32'd0, 3'b100, 1'b0);
        applyStimulus("rd1", 1'b1, 4'd1, 32'd0, 32'h1111_1111, 3'b000, 1'b0);
        applyStimulus("rd3", 1'b1, 4'd3, 32'd0, 32'h3333_3333, 3'b000, 1'b0);

        // STATUS and sticky loss
        applyStimulus("st_nolos", 1'b1, 4'd0, 32'd0, 32'h1234_0001, 3'b000, 1'b0);
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        tick();
        applyStimulus("st_loss", 1'b1, 4'd0, 32'd0, 32'h1234_0003, 3'b000, 1'b0);
        applyStimulus("st_wr1", 1'b0, 4'd0, 32'h0000_0001, 32'd0, 3'b000, 1'b0);
        applyStimulus("st_keep", 1'b1, 4'd0, 32'd0, 32'h1234_0003, 3'b000, 1'b0);
        applyStimulus("st_clr", 1'b0, 4'd0, 32'h0000_0002, 32'd0, 3'b000, 1'b0);
        applyStimulus("st_clrd", 1'b1, 4'd0, 32'd0, 32'h1234_0001, 3'b000, 1'b0);

        // Unmapped addresses
        applyStimulus("rd9", 1'b1, 4'd9, 32'd0, 32'd0, 3'b000, 1'b0);
        applyStimulus("rd4", 1'b1, 4'd4, 32'd0, 32'd0, 3'b000, 1'b0);
        applyStimulus("wr9", 1'b0, 4'd9, 32'hFFFF_FFFF, 32'd0, 3'b000, 1'b0);
        checkOutput("wr9_cfg", cfg_o, {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111});

        // Long request: one access only, last read data (0) held
        fll_web_i   = 1'b0;
        fll_addr_i  = 4'd1;
        fll_wdata_i = 32'hCAFE_0001;
        fll_req_i   = 1'b1;
        pulses      = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (cfg_we_o != 3'b000) pulses++;
            if (i >= 2) begin
                checkOutput("hold_ack",   96'(fll_ack_o),   96'd1);
                checkOutput("hold_rdata", 96'(fll_rdata_o), 96'd0);
            end
        end
        checkOutput("hold_pulses", 96'(pulses), 96'd1);
        checkOutput("hold_cfg", cfg_o, {32'h3333_3333, 32'hDEAD_BEEF, 32'hCAFE_0001});
        fll_req_i = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("hold_ack_off", 96'(fll_ack_o), 96'd0);

        // Lock loss on the same edge as a sticky-clear write: set wins
        applyStimulus("st_race", 1'b0, 4'd0, 32'h0000_0002, 32'd0, 3'b000, 1'b1);
        lock_i = 1'b1;
        tick();
        applyStimulus("st_race_rd", 1'b1, 4'd0, 32'd0, 32'h1234_0003, 3'b000, 1'b0);

        // Reset in the middle of a handshake
        e.tag     = "mid_pre";
        e.is_read = 1'b1;
        e.rdata   = 32'hDEAD_BEEF;
        e.we      = 3'b000;
        sb_q.push_back(e);
        fll_web_i  = 1'b1;
        fll_addr_i = 4'd2;
        fll_req_i  = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("mid_ack_pre", 96'(fll_ack_o), 96'd1);
        got = sb_q.pop_front();
        checkOutput({got.tag, "_rdata"}, 96'(fll_rdata_o), 96'(got.rdata));
        rst_i = 1'b1;
        tick();
        checkOutput("mid_ack_rst",   96'(fll_ack_o),   96'd0);
        checkOutput("mid_rdata_rst", 96'(fll_rdata_o), 96'd0);
        checkOutput("mid_cfg_rst",   cfg_o, {32'hA5, 32'hA5, 32'hA5});
        rst_i = 1'b0;
        e.tag   = "mid_post";
        e.rdata = 32'h0000_00A5;
        sb_q.push_back(e);
        tick();
        checkOutput("mid_ack_r1", 96'(fll_ack_o), 96'd0);
        tick();
        checkOutput("mid_ack_r2", 96'(fll_ack_o), 96'd0);
        tick();
        checkOutput("mid_ack_r3", 96'(fll_ack_o), 96'd1);
        got = sb_q.pop_front();
        checkOutput({got.tag, "_rdata"}, 96'(fll_rdata_o), 96'(got.rdata));
        fll_req_i = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("mid_ack_done", 96'(fll_ack_o), 96'd0);
        checkOutput("sb_empty", 96'(sb_q.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
